// File: rtl/pll_md_ctrl.sv
// pll_md_ctrl: turns host commands into PLL MD-bus cycles and sequences the PLL reset/lock handshake
module pll_md_ctrl #(
  parameter int RESET_CYCLES = 16,
  parameter int LOCK_TIMEOUT = 50000,
  parameter int RD_LAT = 2,
  parameter int CNT_W = 16
) (
  input  logic       mdclk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic [1:0] pll_mdopc,
  output logic       pll_mdainc,
  output logic [7:0] pll_mdwdi,
  input  logic [7:0] pll_mdrdo,
  output logic       pll_reset,
  input  logic       pll_lock,
  output logic       locked,
  output logic       pll_err
);
  localparam logic [2:0] IDLE = 3'd0, ADDR = 3'd1, WR = 3'd2, RD = 3'd3,
                         RD_WAIT = 3'd4, RST_ASSERT = 3'd5, LOCK_WAIT = 3'd6, RESP = 3'd7;
  logic [2:0] state;
  logic [CNT_W-1:0] cnt;
  logic [7:0] wdata;
  logic op_rd, startup, sync1, sync2, lock_done, hold;
  // hold is true when the next state keeps locked forced low
  always_comb begin
    lock_done = sync2 || cnt == CNT_W'(LOCK_TIMEOUT - 1);
    hold = state == RST_ASSERT || (state == LOCK_WAIT && !lock_done) ||
           (state == IDLE && cmd_valid && cmd_op == 2'b10);
  end
  assign pll_mdainc = 1'b0;
  always_ff @(posedge mdclk) begin
    if (reset) begin
      state <= RST_ASSERT;
      cnt <= '0;
      wdata <= 8'h00;
      op_rd <= 1'b0;
      startup <= 1'b1;
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      rsp_err <= 1'b0;
      pll_mdopc <= 2'b00;
      pll_mdwdi <= 8'h00;
      pll_reset <= 1'b1;
      locked <= 1'b0;
      pll_err <= 1'b0;
    end else begin
      sync1 <= pll_lock;
      sync2 <= sync1;
      locked <= sync1 && !hold;
      pll_mdopc <= 2'b00;
      pll_mdwdi <= 8'h00;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      rsp_err <= 1'b0;
      case (state)
        IDLE: if (cmd_valid) begin
          cmd_ready <= 1'b0;
          op_rd <= cmd_op[0];
          wdata <= cmd_wdata;
          if (!cmd_op[1]) begin
            state <= ADDR;
            pll_mdopc <= 2'b11;
            pll_mdwdi <= cmd_addr;
          end else if (!cmd_op[0]) begin
            state <= RST_ASSERT;
            pll_reset <= 1'b1;
            cnt <= '0;
          end else begin
            state <= RESP;
            rsp_valid <= 1'b1;
            rsp_err <= 1'b1;
          end
        end
        ADDR: begin
          state <= op_rd ? RD : WR;
          pll_mdopc <= op_rd ? 2'b10 : 2'b01;
          pll_mdwdi <= op_rd ? 8'h00 : wdata;
        end
        WR: begin
          state <= RESP;
          rsp_valid <= 1'b1;
        end
        RD: begin
          state <= RD_WAIT;
          cnt <= '0;
        end
        RD_WAIT: if (cnt == CNT_W'(RD_LAT - 1)) begin
          state <= RESP;
          rsp_valid <= 1'b1;
          rsp_rdata <= pll_mdrdo;
        end else cnt <= cnt + CNT_W'(1);
        RST_ASSERT: if (cnt == CNT_W'(RESET_CYCLES - 1)) begin
          state <= LOCK_WAIT;
          pll_reset <= 1'b0;
          cnt <= '0;
        end else cnt <= cnt + CNT_W'(1);
        LOCK_WAIT: if (lock_done) begin
          startup <= 1'b0;
          if (startup) begin
            state <= IDLE;
            cmd_ready <= 1'b1;
            pll_err <= !sync2;
          end else begin
            state <= RESP;
            rsp_valid <= 1'b1;
            rsp_err <= !sync2;
          end
        end else cnt <= cnt + CNT_W'(1);
        RESP: begin
          state <= IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pll_md_ctrl.sv
// tb_pll_md_ctrl: directed stimulus with a response scoreboard and a small MD register model
module tb_pll_md_ctrl;
  localparam int RC = 16, LT = 100, RL = 2;
  logic mdclk = 1'b0, reset = 1'b1, cmd_valid = 1'b0, pll_lock = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_addr = 8'h00, cmd_wdata = 8'h00;
  logic cmd_ready, rsp_valid, rsp_err, pll_mdainc, pll_reset, locked, pll_err;
  logic [7:0] rsp_rdata, pll_mdwdi, pll_mdrdo;
  logic [1:0] pll_mdopc;
  int cyc = 0, checks = 0, errors = 0;
  typedef struct {logic [7:0] rdata; logic err; int cyc;} rsp_t;
  rsp_t q[$];
  logic [7:0] mem [256];
  logic [7:0] ma;
  logic [1:0] rd_pipe;

  pll_md_ctrl #(.RESET_CYCLES(RC), .LOCK_TIMEOUT(LT), .RD_LAT(RL), .CNT_W(16)) dut (
    .mdclk(mdclk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .pll_mdopc(pll_mdopc), .pll_mdainc(pll_mdainc), .pll_mdwdi(pll_mdwdi),
    .pll_mdrdo(pll_mdrdo), .pll_reset(pll_reset), .pll_lock(pll_lock),
    .locked(locked), .pll_err(pll_err));

  always #5 mdclk = ~mdclk;
  always @(posedge mdclk) cyc <= cyc + 1;

  // PLL MD register file: address load, write, read data RL cycles after the read opcode
  always @(posedge mdclk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= (i == 8) ? 8'hA7 : 8'h00;
      rd_pipe <= 2'b00;
      ma <= 8'h00;
    end else begin
      if (pll_mdopc == 2'b11) ma <= pll_mdwdi;
      if (pll_mdopc == 2'b01) mem[ma] <= pll_mdwdi;
      rd_pipe <= {rd_pipe[0], pll_mdopc == 2'b10};
    end
  end
  assign pll_mdrdo = rd_pipe[1] ? mem[ma] : 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge mdclk) begin
    if (!reset && rsp_valid) begin : mon
      rsp_t e;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got rsp_valid at cycle %0d expected none", cyc);
      end else begin
        e = q.pop_front();
        if (rsp_rdata !== e.rdata || rsp_err !== e.err || cyc != e.cyc) begin
          errors++;
          $display("FAIL rsp: got rdata=%0h err=%0b cycle=%0d expected rdata=%0h err=%0b cycle=%0d",
                   rsp_rdata, rsp_err, cyc, e.rdata, e.err, e.cyc);
        end
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d, output int h);
    logic r;
    int n;
    @(posedge mdclk);
    #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = d;
    n = 0;
    do begin
      @(negedge mdclk);
      r = cmd_ready;
      @(posedge mdclk);
      #1;
      n++;
    end while (!r && n < 500);
    if (!r) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got no handshake after %0d cycles expected handshake", n);
    end
    h = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_ready(output int c);
    int n;
    n = 0;
    @(negedge mdclk);
    while (!cmd_ready && n < 400) begin
      @(negedge mdclk);
      n++;
    end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL ready_timeout: got cmd_ready=0 after %0d cycles expected 1", n);
    end
    c = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int h, h2, r, n, c;
    repeat (3) @(posedge mdclk);
    @(negedge mdclk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_pll_reset", pll_reset, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_mdopc", pll_mdopc, 0);
    chk("rst_locked", locked, 0);
    chk("rst_pll_err", pll_err, 0);
    // startup: lock arrives 10 cycles after pll_reset falls
    @(posedge mdclk);
    #1 reset = 1'b0;
    n = 0;
    @(negedge mdclk);
    while (pll_reset && n < 100) begin
      n++;
      @(negedge mdclk);
    end
    chk("startup_reset_len", n, RC);
    repeat (10) @(negedge mdclk);
    pll_lock = 1'b1;
    repeat (2) @(negedge mdclk);
    chk("startup_locked_gated", locked, 0);
    @(negedge mdclk);
    chk("startup_locked", locked, 1);
    chk("startup_ready", cmd_ready, 1);
    chk("startup_pll_err", pll_err, 0);
    // write 0x5A to 0x1C
    issue(2'b00, 8'h1C, 8'h5A, h);
    q.push_back('{8'h00, 1'b0, h + 2});
    @(negedge mdclk);
    chk("wr_addr_opc", pll_mdopc, 2'b11);
    chk("wr_addr_wdi", pll_mdwdi, 8'h1C);
    @(negedge mdclk);
    chk("wr_data_opc", pll_mdopc, 2'b01);
    chk("wr_data_wdi", pll_mdwdi, 8'h5A);
    @(negedge mdclk);
    chk("wr_idle_opc", pll_mdopc, 2'b00);
    chk("mdainc", pll_mdainc, 0);
    wait_ready(c);
    // read 0x08, preset to 0xA7
    issue(2'b01, 8'h08, 8'h00, h);
    q.push_back('{8'hA7, 1'b0, h + RL + 2});
    @(negedge mdclk);
    chk("rd_addr_opc", pll_mdopc, 2'b11);
    chk("rd_addr_wdi", pll_mdwdi, 8'h08);
    @(negedge mdclk);
    chk("rd_opc", pll_mdopc, 2'b10);
    @(negedge mdclk);
    chk("rd_idle_opc", pll_mdopc, 2'b00);
    wait_ready(c);
    // reserved op
    issue(2'b11, 8'h55, 8'h33, h);
    q.push_back('{8'h00, 1'b1, h});
    @(negedge mdclk);
    chk("rsv_opc", pll_mdopc, 2'b00);
    chk("rsv_wdi", pll_mdwdi, 8'h00);
    wait_ready(c);
    // read back 0x1C with the next command held pending
    issue(2'b01, 8'h1C, 8'h00, h);
    q.push_back('{8'h5A, 1'b0, h + RL + 2});
    issue(2'b11, 8'h00, 8'h00, h2);
    q.push_back('{8'h00, 1'b1, h2});
    chk("held_accept_cycle", h2, h + RL + 4);
    wait_ready(c);
    // lock drop in IDLE
    @(posedge mdclk);
    #1 pll_lock = 1'b0;
    @(negedge mdclk);
    @(negedge mdclk);
    chk("drop_locked_hold", locked, 1);
    @(negedge mdclk);
    chk("drop_locked", locked, 0);
    // apply with lock held low: timeout
    issue(2'b10, 8'h00, 8'h00, h);
    q.push_back('{8'h00, 1'b1, h + RC + LT});
    repeat (RC) @(negedge mdclk);
    chk("apply_reset_last", pll_reset, 1);
    @(negedge mdclk);
    chk("apply_reset_fall", pll_reset, 0);
    chk("apply_locked_gated", locked, 0);
    wait_ready(c);
    chk("apply_to_pll_err", pll_err, 0);
    chk("apply_to_locked", locked, 0);
    // apply with lock present
    pll_lock = 1'b1;
    issue(2'b10, 8'h00, 8'h00, h);
    q.push_back('{8'h00, 1'b0, h + RC + 1});
    wait_ready(c);
    chk("apply_ok_locked", locked, 1);
    // startup timeout sets sticky pll_err
    @(posedge mdclk);
    #1 pll_lock = 1'b0; reset = 1'b1;
    repeat (2) @(posedge mdclk);
    #1 reset = 1'b0;
    r = cyc;
    wait_ready(c);
    chk("startup_to_cycle", c, r + RC + LT);
    chk("startup_to_pll_err", pll_err, 1);
    chk("startup_to_locked", locked, 0);
    pll_lock = 1'b1;
    issue(2'b10, 8'h00, 8'h00, h);
    q.push_back('{8'h00, 1'b0, h + RC + 1});
    wait_ready(c);
    chk("pll_err_sticky", pll_err, 1);
    // reset during LOCK_WAIT of an apply
    @(posedge mdclk);
    #1 pll_lock = 1'b0;
    issue(2'b10, 8'h00, 8'h00, h);
    repeat (30) @(negedge mdclk);
    chk("abort_in_lock_wait", pll_reset, 0);
    @(posedge mdclk);
    #1 reset = 1'b1;
    @(posedge mdclk);
    #1;
    @(negedge mdclk);
    chk("abort_pll_reset", pll_reset, 1);
    chk("abort_ready", cmd_ready, 0);
    chk("abort_pll_err", pll_err, 0);
    @(posedge mdclk);
    #1 reset = 1'b0; pll_lock = 1'b1;
    wait_ready(c);
    chk("restart_locked", locked, 1);
    chk("restart_pll_err", pll_err, 0);
    repeat (5) @(negedge mdclk);
    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
